// File: rtl/jtag_bsr_chain_if.sv
// TAP-side signal bundle for the boundary-scan register: DR strobes, instruction selects, serial data.
// With JTAG_BSR_INTEST_EN defined the bundle also carries intest_select_i.
interface jtag_bsr_chain_if;
  logic tdi_i;
  logic capture_dr_i;
  logic shift_dr_i;
  logic update_dr_i;
  logic extest_select_i;
  logic sample_preload_select_i;
`ifdef JTAG_BSR_INTEST_EN
  logic intest_select_i;
`endif
  logic bs_chain_tdo_o;

  // The TAP controller drives strobes and selects and receives the chain output.
  modport master (
    output tdi_i, capture_dr_i, shift_dr_i, update_dr_i,
    output extest_select_i, sample_preload_select_i,
`ifdef JTAG_BSR_INTEST_EN
    output intest_select_i,
`endif
    input  bs_chain_tdo_o
  );

  modport slave (
    input  tdi_i, capture_dr_i, shift_dr_i, update_dr_i,
    input  extest_select_i, sample_preload_select_i,
`ifdef JTAG_BSR_INTEST_EN
    input  intest_select_i,
`endif
    output bs_chain_tdo_o
  );
endinterface

// File: rtl/jtag_bsr_chain.sv
// Boundary-scan register between pads and core: capture/shift/update cells plus pad/core muxing.
// Optional INTEST support is enabled with the macro JTAG_BSR_INTEST_EN.
module jtag_bsr_chain #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2
) (
  input  logic              tck_pad_i,
  input  logic              trst_n_pad_i,
  jtag_bsr_chain_if.slave   tap,
  input  logic [N_IN-1:0]   pad_in_i,
  output logic [N_IN-1:0]   core_in_o,
  input  logic [N_OUT-1:0]  core_out_i,
  input  logic [N_OUT-1:0]  core_oe_i,
  output logic [N_OUT-1:0]  pad_out_o,
  output logic [N_OUT-1:0]  pad_oe_o
);

  localparam int L     = N_IN + 2 * N_OUT;
  localparam int OD_LO = N_IN;
  localparam int OE_LO = N_IN + N_OUT;

  logic [L-1:0] sr_q, sr_d;
  logic [L-1:0] ur_q, ur_d;
  logic         tdo_q;
  logic         sel;
  logic         drive_from_ur;

`ifdef JTAG_BSR_INTEST_EN
  assign sel           = tap.extest_select_i | tap.sample_preload_select_i | tap.intest_select_i;
  // EXTEST and INTEST both source pads and core from ur, so their relative priority is moot here.
  assign drive_from_ur = tap.extest_select_i | tap.intest_select_i;
`else
  assign sel           = tap.extest_select_i | tap.sample_preload_select_i;
  assign drive_from_ur = tap.extest_select_i;
`endif

  // Capture beats shift beats update when several strobes are high together.
  always_comb begin
    // NOTE: defaults first so every path assigns sr_d/ur_d and no latch is inferred.
    sr_d = sr_q;
    ur_d = ur_q;
    if (sel) begin
      if (tap.capture_dr_i) begin
        sr_d = {core_oe_i, core_out_i, pad_in_i};
      end else if (tap.shift_dr_i) begin
        sr_d = {tap.tdi_i, sr_q[L-1:1]};
      end else if (tap.update_dr_i) begin
        ur_d = sr_q;
      end
    end
  end

  always_ff @(posedge tck_pad_i or negedge trst_n_pad_i) begin
    if (!trst_n_pad_i) begin
      // NOTE: non-blocking assignments keep register updates order-independent across processes.
      sr_q <= '0;
      ur_q <= '0;
    end else begin
      sr_q <= sr_d;
      ur_q <= ur_d;
    end
  end

  // Launching TDO on the falling edge gives the TAP's combinational mux a half-cycle of margin.
  always_ff @(negedge tck_pad_i or negedge trst_n_pad_i) begin
    if (!trst_n_pad_i) begin
      tdo_q <= 1'b0;
    end else begin
      tdo_q <= sr_q[0];
    end
  end

  assign tap.bs_chain_tdo_o = tdo_q;

  // A cleared ur means EXTEST without PRELOAD leaves pads tristated and driving zero.
  always_comb begin
    if (drive_from_ur) begin
      pad_out_o = ur_q[OE_LO-1:OD_LO];
      pad_oe_o  = ur_q[L-1:OE_LO];
      core_in_o = ur_q[N_IN-1:0];
    end else begin
      pad_out_o = core_out_i;
      pad_oe_o  = core_oe_i;
      core_in_o = pad_in_i;
    end
  end

endmodule

// File: tb/tb_jtag_bsr_chain.sv
// Self-checking bench for jtag_bsr_chain (N_IN=2, N_OUT=2): reference model feeds a scoreboard of
// expected TDO and pad/core values, compared half a cycle after each active edge.
module tb_jtag_bsr_chain;
  localparam int N_IN  = 2;
  localparam int N_OUT = 2;
  localparam int L     = N_IN + 2 * N_OUT;

  typedef struct packed {
    logic             tdo;
    logic [N_OUT-1:0] pad_out;
    logic [N_OUT-1:0] pad_oe;
    logic [N_IN-1:0]  core_in;
  } obs_t;

  logic              tck = 1'b0;
  logic              trst_n = 1'b0;
  logic [N_IN-1:0]   pad_in = '0;
  logic [N_IN-1:0]   core_in;
  logic [N_OUT-1:0]  core_out = '0;
  logic [N_OUT-1:0]  core_oe = '0;
  logic [N_OUT-1:0]  pad_out;
  logic [N_OUT-1:0]  pad_oe;

  int checks = 0;
  int errors = 0;

  logic [L-1:0] sr_m = '0;
  logic [L-1:0] ur_m = '0;
  logic         tdo_m = 1'b0;
  obs_t         sb[$];

  jtag_bsr_chain_if tap_if ();

  jtag_bsr_chain #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .tck_pad_i    (tck),
    .trst_n_pad_i (trst_n),
    .tap          (tap_if),
    .pad_in_i     (pad_in),
    .core_in_o    (core_in),
    .core_out_i   (core_out),
    .core_oe_i    (core_oe),
    .pad_out_o    (pad_out),
    .pad_oe_o     (pad_oe)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic obs_t observe();
    obs_t o;
    o.tdo     = tap_if.bs_chain_tdo_o;
    o.pad_out = pad_out;
    o.pad_oe  = pad_oe;
    o.core_in = core_in;
    return o;
  endfunction

  function automatic obs_t model_expect();
    obs_t e;
    e.tdo = tdo_m;
    if (tap_if.extest_select_i) begin
      e.pad_out = ur_m[N_IN+N_OUT-1:N_IN];
      e.pad_oe  = ur_m[L-1:N_IN+N_OUT];
      e.core_in = ur_m[N_IN-1:0];
    end else begin
      e.pad_out = core_out;
      e.pad_oe  = core_oe;
      e.core_in = pad_in;
    end
    return e;
  endfunction

  // One TCK cycle: drive strobes, advance the model, push expectation, compare after the falling edge.
  task automatic step(input logic cap, input logic sh, input logic upd, input logic tdi,
                      input string tag);
    obs_t exp_v;
    obs_t got;
    tap_if.capture_dr_i = cap;
    tap_if.shift_dr_i   = sh;
    tap_if.update_dr_i  = upd;
    tap_if.tdi_i        = tdi;
    if (tap_if.extest_select_i | tap_if.sample_preload_select_i) begin
      if (cap)      sr_m = {core_oe, core_out, pad_in};
      else if (sh)  sr_m = {tdi, sr_m[L-1:1]};
      else if (upd) ur_m = sr_m;
    end
    tdo_m = sr_m[0];
    sb.push_back(model_expect());
    @(posedge tck);
    @(negedge tck);
    #1;
    tap_if.capture_dr_i = 1'b0;
    tap_if.shift_dr_i   = 1'b0;
    tap_if.update_dr_i  = 1'b0;
    got   = observe();
    exp_v = sb.pop_front();
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: tdo/pad_out/pad_oe/core_in got %b %b %b %b expected %b %b %b %b",
               tag, got.tdo, got.pad_out, got.pad_oe, got.core_in,
               exp_v.tdo, exp_v.pad_out, exp_v.pad_oe, exp_v.core_in);
    end
  endtask

  task automatic test_reset();
    obs_t got;
    tap_if.extest_select_i = 1'b0;
    tap_if.sample_preload_select_i = 1'b0;
    core_out = 2'b10; core_oe = 2'b11; pad_in = 2'b01;
    trst_n = 1'b0;
    repeat (3) @(posedge tck);
    @(negedge tck);
    #1 trst_n = 1'b1;
    sr_m = '0; ur_m = '0; tdo_m = 1'b0;
    #1 got = observe();
    checks++;
    if (got !== {1'b0, 2'b10, 2'b11, 2'b01}) begin
      errors++;
      $display("FAIL reset_idle: tdo/pad_out/pad_oe/core_in got %b %b %b %b expected 0 10 11 01",
               got.tdo, got.pad_out, got.pad_oe, got.core_in);
    end
    tap_if.extest_select_i = 1'b1;
    #1 got = observe();
    checks++;
    if (got !== {1'b0, 2'b00, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL reset_extest_safe: tdo/pad_out/pad_oe/core_in got %b %b %b %b expected 0 00 00 00",
               got.tdo, got.pad_out, got.pad_oe, got.core_in);
    end
    tap_if.extest_select_i = 1'b0;
    #1;
  endtask

  task automatic test_sample();
    tap_if.sample_preload_select_i = 1'b1;
    pad_in = 2'b10; core_out = 2'b01; core_oe = 2'b11;
    step(1'b1, 1'b0, 1'b0, 1'b0, "sample_capture");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, $sformatf("sample_shift%0d", i));
  endtask

  task automatic test_preload_extest();
    logic [L-1:0] bits;
    obs_t got;
    bits = 6'b110101;
    for (int i = 0; i < L; i++) step(1'b0, 1'b1, 1'b0, bits[i], $sformatf("preload_shift%0d", i));
    step(1'b0, 1'b0, 1'b1, 1'b0, "preload_update");
    tap_if.sample_preload_select_i = 1'b0;
    tap_if.extest_select_i = 1'b1;
    #1 got = observe();
    checks++;
    if ({got.pad_out, got.pad_oe, got.core_in} !== {2'b01, 2'b11, 2'b01}) begin
      errors++;
      $display("FAIL extest_pads: pad_out/pad_oe/core_in got %b %b %b expected 01 11 01",
               got.pad_out, got.pad_oe, got.core_in);
    end
    tap_if.extest_select_i = 1'b0;
    #1 got = observe();
    checks++;
    if ({got.pad_out, got.pad_oe, got.core_in} !== {core_out, core_oe, pad_in}) begin
      errors++;
      $display("FAIL extest_release: pad_out/pad_oe/core_in got %b %b %b expected %b %b %b",
               got.pad_out, got.pad_oe, got.core_in, core_out, core_oe, pad_in);
    end
  endtask

  task automatic test_no_select();
    for (int i = 0; i < L; i++) step(1'b0, 1'b1, 1'b0, 1'b1, $sformatf("nosel_shift%0d", i));
    step(1'b0, 1'b0, 1'b1, 1'b1, "nosel_update");
    // ur still holds the preload; sr is drained under EXTEST while pads must stay put.
    tap_if.extest_select_i = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, "nosel_ur_kept");
    for (int i = 0; i < L; i++) step(1'b0, 1'b1, 1'b0, 1'b1, $sformatf("extest_drain%0d", i));
  endtask

  task automatic test_reset_mid_shift();
    obs_t got;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, $sformatf("midshift%0d", i));
    tap_if.shift_dr_i = 1'b1;
    trst_n = 1'b0;
    sr_m = '0; ur_m = '0; tdo_m = 1'b0;
    #1 got = observe();
    checks++;
    if (got !== {1'b0, 2'b00, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_shift: tdo/pad_out/pad_oe/core_in got %b %b %b %b expected 0 00 00 00",
               got.tdo, got.pad_out, got.pad_oe, got.core_in);
    end
    tap_if.shift_dr_i = 1'b0;
    @(posedge tck);
    @(negedge tck);
    #1 trst_n = 1'b1;
    tap_if.extest_select_i = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [L-1:0] bits;
    obs_t got;
    bits = 6'b100110;
    tap_if.sample_preload_select_i = 1'b1;
    for (int i = 0; i < L; i++) step(1'b0, 1'b1, 1'b0, bits[i], $sformatf("simul_load%0d", i));
    pad_in = 2'b11; core_out = 2'b00; core_oe = 2'b10;
    step(1'b1, 1'b1, 1'b1, 1'b0, "simul_strobes");
    tap_if.extest_select_i = 1'b1;
    #1 got = observe();
    checks++;
    if ({got.pad_out, got.pad_oe, got.core_in} !== {2'b00, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL simul_ur_unchanged: pad_out/pad_oe/core_in got %b %b %b expected 00 00 00",
               got.pad_out, got.pad_oe, got.core_in);
    end
    for (int i = 0; i < L; i++) step(1'b0, 1'b1, 1'b0, 1'b0, $sformatf("simul_unload%0d", i));
  endtask

  initial begin
    tap_if.tdi_i = 1'b0;
    tap_if.capture_dr_i = 1'b0;
    tap_if.shift_dr_i = 1'b0;
    tap_if.update_dr_i = 1'b0;
    tap_if.extest_select_i = 1'b0;
    tap_if.sample_preload_select_i = 1'b0;
`ifdef JTAG_BSR_INTEST_EN
    tap_if.intest_select_i = 1'b0;
`endif
    test_reset();
    test_sample();
    test_preload_extest();
    test_no_select();
    test_reset_mid_shift();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_bsr_chain.md
Name: jtag_bsr_chain

Overview:
- Boundary-scan register (BSR) for the DFT wrapper. It sits directly upstream of the TAP controller's bs_chain_tdi_i input.
- Consumes the TAP's DR-state strobes, its EXTEST/SAMPLE-PRELOAD selects and its serial TDI copy (tdo_o).
- Returns the chain's serial output, which the TAP muxes onto TDO.
- Inserts between pads and core: pass-through in functional mode; update-register values drive pads (and core inputs) under EXTEST.

Parameters:
- N_IN, 2, number of core input pins (input cells)
- N_OUT, 2, number of core output pins; each pin has one data cell and one output-enable cell
- (derived) L = N_IN + 2*N_OUT, total chain length

Ports:
- tck_pad_i  in  1  JTAG test clock; single clock, both edges used
- trst_n_pad_i  in  1  asynchronous active-low reset
- tdi_i  in  1  serial data from TAP (tdo_o)
- capture_dr_i  in  1  TAP Capture-DR state
- shift_dr_i  in  1  TAP Shift-DR state
- update_dr_i  in  1  TAP Update-DR state
- extest_select_i  in  1  EXTEST instruction active
- sample_preload_select_i  in  1  SAMPLE/PRELOAD instruction active
- pad_in_i  in  N_IN  values from input pads
- core_in_o  out  N_IN  to core inputs
- core_out_i  in  N_OUT  core output data
- core_oe_i  in  N_OUT  core output enables
- pad_out_o  out  N_OUT  to output pads
- pad_oe_o  out  N_OUT  to pad output enables
- bs_chain_tdo_o  out  1  serial output to TAP bs_chain_tdi_i

Behaviour:
- Chain map (shift register sr[L-1:0]):
  - sr[N_IN-1:0]: input cells
  - sr[N_IN+N_OUT-1:N_IN]: output data cells
  - sr[L-1:N_IN+N_OUT]: output-enable cells
- Update register ur[L-1:0] uses the same map.
- Serial direction: tdi_i enters sr[L-1]; sr[0] leaves the chain. LSB is shifted out first.
- sel = extest_select_i | sample_preload_select_i. If sel=0, sr and ur hold on every edge.
- Posedge tck_pad_i, when sel=1, priority capture > shift > update:
  - capture_dr_i: sr <= {core_oe_i, core_out_i, pad_in_i}.
  - shift_dr_i: sr <= {tdi_i, sr[L-1:1]}.
  - update_dr_i: ur <= sr.
- Negedge tck_pad_i: bs_chain_tdo_o <= sr[0]. This gives half-cycle TDO timing; the TAP mux is combinational.
- Output muxing (combinational):
  - extest_select_i=1: pad_out_o = ur[N_IN+N_OUT-1:N_IN]; pad_oe_o = ur[L-1:N_IN+N_OUT]; core_in_o = ur[N_IN-1:0].
  - otherwise: pad_out_o = core_out_i; pad_oe_o = core_oe_i; core_in_o = pad_in_i (transparent; SAMPLE is non-intrusive).
- Reset (trst_n_pad_i low, async):
  - sr=0, ur=0, bs_chain_tdo_o=0.
  - If EXTEST is entered with no PRELOAD, pads are tristated (oe=0) and pad_out_o=0.
- Reset mid-shift clears the partially shifted data. There is no resume.
- ur changes only on update_dr_i. Shifting never disturbs pad values during EXTEST.
- Selects may change at any time; the output mux follows extest_select_i combinationally.

Optional Feature:
- Macro: JTAG_BSR_INTEST_EN.
- Defined:
  - Adds input port intest_select_i (1 bit); sel also includes intest_select_i.
  - When intest_select_i=1: core_in_o = ur[N_IN-1:0]; pad_out_o = ur output-data cells; pad_oe_o = ur OE cells (safe pad state).
  - Capture uses the same sources as above.
  - extest_select_i has priority if both selects are high.
- Not defined: the port is absent and behaviour is as above.

Test Plan (N_IN=2, N_OUT=2, L=6):
1. Reset:
   - Stimulus: trst_n_pad_i=0 with tck running, then release. sel=0, core_out_i=2'b10, core_oe_i=2'b11, pad_in_i=2'b01.
   - Required: bs_chain_tdo_o=0; pad_out_o=2'b10, pad_oe_o=2'b11, core_in_o=2'b01.
2. SAMPLE:
   - Stimulus: sample_preload_select_i=1, pad_in_i=2'b10, core_out_i=2'b01, core_oe_i=2'b11; 1 capture cycle, then 5 shift cycles with tdi_i=0.
   - Required: bs_chain_tdo_o after successive negedges = 0,1,1,0,1,1; pads stay transparent throughout.
3. PRELOAD then EXTEST:
   - Stimulus: shift tdi_i=1,0,1,0,1,1 (6 cycles), update_dr_i 1 cycle, then set extest_select_i=1.
   - Required: ur=6'b110101; pad_out_o=2'b01, pad_oe_o=2'b11, core_in_o=2'b01. Dropping extest_select_i restores pass-through.
4. No selection:
   - Stimulus: sel=0, 6 shift and 1 update cycles with tdi_i=1.
   - Required: sr and ur unchanged; bs_chain_tdo_o unchanged.
5. Reset mid-shift:
   - Stimulus: EXTEST with ur=6'b110101; 3 shift cycles, then assert trst_n_pad_i=0.
   - Required: immediately pad_oe_o=2'b00, pad_out_o=2'b00, core_in_o=2'b00, bs_chain_tdo_o=0.
6. Simultaneous strobes:
   - Stimulus: capture_dr_i=shift_dr_i=update_dr_i=1 for one posedge with sel=1.
   - Required: sr equals captured vector {core_oe_i,core_out_i,pad_in_i}; ur unchanged.
